mem_port_ctrl: RTL and testbench
================================

Name: mem_port_ctrl

Overview:
- Sequencer/arbiter that shares the single-port word memory (14-bit word address, combinational read, negedge write) between the instruction-fetch requester and the load/store requester.
- Accepts byte-addressed requests and performs sub-word stores as read-modify-write, issuing only full-word writes to memory.
- Extracts and sign-/zero-extends sub-word load data and returns it with a one-cycle valid pulse.
- Sits between the core pipeline and the memory block.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced (range 1..15).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  16  fetch byte address.
- if_ready  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response pulse.
- if_rdata  out  32  instruction word.
- if_err  out  1  misaligned fetch; valid with if_rvalid.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  16  data byte address.
- d_type  in  3  funct3: LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5.
- d_wdata  in  32  store data, right-aligned.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response pulse (load data or store ack).
- d_rdata  out  32  extended load data; 0 for stores.
- d_err  out  1  misaligned/illegal access; valid with d_rvalid.
- mem_addr  out  14  memory word address.
- mem_we  out  1  memory write enable, held for the whole cycle.
- mem_type  out  3  always SW (2) when writing, LW (2) when reading.
- mem_wdata  out  32  full merged word.
- mem_rdata  in  32  memory read word (combinational).

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; starvation counter cleared.
  - All outputs 0, including ready signals; mem_we drops immediately, so there is no partial write.
  - An in-flight access is abandoned with no response.
- Requester contract:
  - Requester holds req, addr, type and wdata stable until it samples ready=1.
  - At most one transaction is outstanding in the whole block.
- FSM states: IDLE, READ, WRITE, MERGE_WRITE, DONE.
- IDLE:
  - Arbiter picks a winner; the winner's ready=1 combinationally, the loser's ready=0.
  - On the accepting edge, latch source, addr, type, we and wdata.
  - Checks at latch time:
    - Misaligned fetch: if_addr[1:0] != 0.
    - Misaligned data access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0] != 0.
    - Illegal data type: type 3/6/7, or type 4/5 with we=1.
    - On any check failure: go to DONE with err=1 and no memory access.
  - Next state for legal requests:
    - Load or fetch -> READ.
    - SW -> WRITE.
    - SB/SH -> READ, with the RMW flag set.
- READ:
  - mem_addr = latched addr[15:2], mem_we = 0.
  - mem_rdata is captured into the read buffer at the clock edge.
  - Next state: MERGE_WRITE if RMW, else DONE.
- WRITE: mem_we=1, mem_wdata=d_wdata; next DONE.
- MERGE_WRITE:
  - mem_we=1; mem_wdata = read buffer with the target lane replaced.
  - SB: byte lane addr[1:0] gets wdata[7:0].
  - SH: half addr[1] gets wdata[15:0].
  - Next DONE.
- DONE:
  - Owner's rvalid=1 for exactly one cycle, with rdata and err; next IDLE.
  - No request is accepted in DONE.
- Load extraction from the read buffer:
  - LB/LBU: byte addr[1:0], sign/zero extended.
  - LH/LHU: half addr[1], sign/zero extended.
  - LW and fetch: whole word.
  - rdata = 0 when err=1 or for stores.
- Latency, counted from the accepting edge:
  - Loads, fetches and SW: rvalid high in the 2nd cycle; occupancy 3 cycles.
  - SB/SH: rvalid in the 3rd cycle; occupancy 4 cycles.
  - Errors: rvalid in the 1st cycle; occupancy 2 cycles.
- Back-to-back: the next accept is possible in the IDLE cycle immediately after DONE.
- Arbitration:
  - Data has priority over fetch.
  - The counter increments on each data grant while if_req=1, and clears on a fetch grant or when if_req=0.
  - When counter == STARVE_LIMIT and both requesters are requesting, fetch wins.
  - The counter saturates and does not wrap.
- Outputs are registered except ready, which is combinational from state, req and counter.
- No mem_we is ever asserted for an err transaction.

Test Plan:
- Fetch if_addr=0x0010 with mem word 4 = 0x00C0FFEE:
  - if_ready in cycle 0, if_rvalid in cycle 2.
  - if_rdata=0x00C0FFEE, if_err=0.
- SB d_addr=0x0013, d_wdata=0xAB, over word 4 = 0x11223344:
  - Exactly one mem_we cycle, writing 0xAB223344.
  - d_rvalid 3 cycles after accept.
  - A following LB at 0x0013 returns 0xFFFFFFAB; LBU at 0x0013 returns 0x000000AB.
- LH d_addr=0x0012 over 0xAB223344: d_rdata=0xFFFFAB22. LHU at the same address returns 0x0000AB22.
- Misaligned SW d_addr=0x0006:
  - d_rvalid in cycle 1 with d_err=1.
  - mem_we never asserted; memory unchanged.
- d_req and if_req held high continuously, STARVE_LIMIT=4: grant order D,D,D,D,I,D,D,D,D,I.
- rst_n pulsed low during MERGE_WRITE of an SH:
  - mem_we falls asynchronously; no d_rvalid is issued.
  - FSM is in IDLE after release; the target word is unchanged.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
//   Shares one single-port word memory between the instruction-fetch port and
//   the load/store port. Requests are byte addressed; sub-word stores are done
//   as read-modify-write so the memory only ever sees full-word writes. Load
//   data is lane-extracted and sign/zero extended before it is returned.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request and byte address
//   if_ready                   fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata/if_err  one-cycle fetch response
//   d_req/d_we/d_addr/d_type/d_wdata   load/store request (funct3 encoding)
//   d_ready                    data request accepted this cycle (combinational)
//   d_rvalid/d_rdata/d_err     one-cycle data response (load data or store ack)
//   mem_addr/mem_we/mem_type/mem_wdata/mem_rdata   word memory interface
module mem_port_ctrl #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [2:0]  d_type,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [13:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_MERGE_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg, state_next;
    logic [3:0]  starve_cnt_reg, starve_cnt_next;
    logic        src_fetch_reg;
    logic        we_reg;
    logic        err_reg;
    logic        rmw_reg;
    logic [15:0] addr_reg;
    logic [2:0]  type_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rbuf_reg;

    // ---------------- arbitration and request checks ----------------
    logic        force_fetch, d_grant, i_grant, accept;
    logic        data_err, fetch_err, new_err;
    logic [15:0] req_addr;

    // After STARVE_LIMIT data grants with fetch waiting, fetch takes the slot.
    // rst_n gates the grants so ready reads 0 while reset is held.
    assign force_fetch = if_req && (starve_cnt_reg == LIMIT);
    assign d_grant     = rst_n && (state_reg == S_IDLE) && d_req && !force_fetch;
    assign i_grant     = rst_n && (state_reg == S_IDLE) && if_req && !d_grant;
    assign accept      = d_grant || i_grant;
    assign d_ready     = d_grant;
    assign if_ready    = i_grant;
    assign req_addr    = d_grant ? d_addr : if_addr;
    assign fetch_err   = |if_addr[1:0];
    assign new_err     = d_grant ? data_err : fetch_err;

    always_comb begin
        data_err = 1'b1;
        case (d_type)
            3'd0:    data_err = 1'b0;
            3'd1:    data_err = d_addr[0];
            3'd2:    data_err = |d_addr[1:0];
            3'd4:    data_err = d_we;              // LBU has no store form
            3'd5:    data_err = d_we || d_addr[0]; // LHU has no store form
            default: data_err = 1'b1;
        endcase
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || i_grant)
            starve_cnt_next = '0;
        else if (d_grant && starve_cnt_reg < LIMIT)
            starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            starve_cnt_reg <= '0;
            src_fetch_reg  <= 1'b0;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            rmw_reg        <= 1'b0;
            addr_reg       <= '0;
            type_reg       <= '0;
            wdata_reg      <= '0;
            rbuf_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            if (accept) begin
                src_fetch_reg <= i_grant;
                addr_reg      <= req_addr;
                type_reg      <= d_grant ? d_type : 3'd2;
                we_reg        <= d_grant && d_we;
                wdata_reg     <= d_wdata;
                err_reg       <= new_err;
                rmw_reg       <= d_grant && d_we && !new_err && (d_type != 3'd2);
            end
            if (state_reg == S_READ)
                rbuf_reg <= mem_rdata;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (new_err)
                        state_next = S_DONE;
                    else if (d_grant && d_we && d_type == 3'd2)
                        state_next = S_WRITE;
                    else
                        state_next = S_READ;  // loads, fetches, SB/SH read phase
                end
            end
            S_READ:        state_next = rmw_reg ? S_MERGE_WRITE : S_DONE;
            S_WRITE:       state_next = S_DONE;
            S_MERGE_WRITE: state_next = S_DONE;
            S_DONE:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // ---------------- store merge: one lane per byte ----------------
    logic [31:0] merged;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_sel;
            logic [7:0] store_byte;
            // SB targets one byte lane; SH targets both lanes of half addr[1]
            assign lane_sel   = (type_reg[1:0] == 2'd0) ? (addr_reg[1:0] == 2'(gi))
                                                        : (addr_reg[1] == 1'(gi / 2));
            assign store_byte = (type_reg[1:0] == 2'd0) ? wdata_reg[7:0]
                                                        : wdata_reg[8*(gi%2) +: 8];
            assign merged[8*gi +: 8] = lane_sel ? store_byte : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    // ---------------- load extraction ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data, resp_data;

    assign ld_byte = rbuf_reg[{addr_reg[1:0], 3'b000} +: 8];
    assign ld_half = addr_reg[1] ? rbuf_reg[31:16] : rbuf_reg[15:0];

    always_comb begin
        load_data = rbuf_reg;
        case (type_reg[1:0])
            2'd0:    load_data = {{24{~type_reg[2] & ld_byte[7]}}, ld_byte};
            2'd1:    load_data = {{16{~type_reg[2] & ld_half[15]}}, ld_half};
            default: load_data = rbuf_reg;
        endcase
    end

    assign resp_data = (err_reg || we_reg) ? 32'd0 : load_data;

    // ---------------- FSM: outputs (decoded from registered state) ----------------
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_err    = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_type  = '0;
        mem_wdata = '0;
        case (state_reg)
            S_READ: begin
                mem_addr = addr_reg[15:2];
                mem_type = 3'd2;
            end
            S_WRITE: begin
                mem_addr  = addr_reg[15:2];
                mem_we    = 1'b1;
                mem_type  = 3'd2;
                mem_wdata = wdata_reg;
            end
            S_MERGE_WRITE: begin
                mem_addr  = addr_reg[15:2];
                mem_we    = 1'b1;
                mem_type  = 3'd2;
                mem_wdata = merged;
            end
            S_DONE: begin
                if (src_fetch_reg) begin
                    if_rvalid = 1'b1;
                    if_rdata  = resp_data;
                    if_err    = err_reg;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = resp_data;
                    d_err    = err_reg;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed cases, starvation ordering,
// reset during a merge write, then randomized traffic checked against a
// byte-level reference memory model.
module tb_mem_port_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_ready, if_rvalid, if_err;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_ready, d_rvalid, d_err;
    logic [15:0] d_addr;
    logic [2:0]  d_type;
    logic [31:0] d_wdata, d_rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_type(d_type),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_type(mem_type),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, negedge write.
    logic [31:0] mem [0:16383];
    assign mem_rdata = mem[mem_addr];
    always @(negedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Reference copy of the words the bench touches (byte addresses 0..63).
    logic [31:0] ref_mem [0:15];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // One complete transaction on one port, checked against the reference model.
    task automatic do_txn(input bit fetch, input bit we, input logic [2:0] typ,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
        int          size, off, wait_c, lat, writes, exp_lat, exp_writes;
        bit          uns, illegal, seen, exp_err, got_err;
        logic [31:0] word, new_word, exp_rdata, shifted;

        // reference model: byte-level view of the access
        size = 4; uns = 0; illegal = 0;
        if (!fetch) begin
            case (typ)
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                3'd4: begin size = 1; uns = 1; end
                3'd5: begin size = 2; uns = 1; end
                default: illegal = 1;
            endcase
            if (uns && we) illegal = 1;
        end
        off       = int'(addr[1:0]);
        exp_err   = illegal || (off % size != 0);
        word      = ref_mem[addr[5:2]];
        new_word  = word;
        exp_rdata = 32'd0;
        if (exp_err) begin
            exp_lat = 1; exp_writes = 0;
        end else if (!fetch && we) begin
            for (int i = 0; i < size; i++) new_word[8*(off+i) +: 8] = wdata[8*i +: 8];
            exp_lat = (size == 4) ? 2 : 3; exp_writes = 1;
        end else begin
            shifted = word >> (8 * off);
            if (size == 1)      exp_rdata = uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            else if (size == 2) exp_rdata = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            else                exp_rdata = word;
            exp_lat = 2; exp_writes = 0;
        end

        @(negedge clk);
        if (fetch) begin
            if_req = 1; if_addr = addr;
        end else begin
            d_req = 1; d_we = we; d_type = typ; d_addr = addr; d_wdata = wdata;
        end
        #1;
        wait_c = 0;
        while (!(fetch ? if_ready : d_ready) && wait_c < 20) begin
            @(negedge clk); #1; wait_c++;
        end
        check_val("accept_wait", wait_c, 0);
        @(posedge clk); #1;
        if_req = 0; d_req = 0;

        lat = 0; writes = 0; seen = 0; got = 32'd0; got_err = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (mem_we) writes++;
            if (fetch ? if_rvalid : d_rvalid) begin
                seen = 1; lat = c;
                got = fetch ? if_rdata : d_rdata;
                got_err = fetch ? if_err : d_err;
            end
        end
        check_val("latency", lat, exp_lat);
        check_val("rdata", got, exp_rdata);
        check_val("err", {31'd0, got_err}, {31'd0, exp_err});
        check_val("write_cycles", writes, exp_writes);
        ref_mem[addr[5:2]] = new_word;
        check_val("mem_word", mem[addr[5:2]], new_word);
        @(negedge clk);
        check_val("rvalid_pulse", {31'd0, fetch ? if_rvalid : d_rvalid}, 32'd0);
        $display("[TB] txn %s we=%0d type=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 fetch ? "I" : "D", we, typ, addr, wdata, got, got_err, lat);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] sh_word;
        int          k, bad_rv;
        bit          fetch, we;
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [2:0]  types [0:6];

        types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        // reset: requests present but everything must read 0
        rst_n = 0; if_req = 1; if_addr = 16'h0; d_req = 1; d_we = 0;
        d_type = 3'd2; d_addr = 16'h0; d_wdata = 32'h0;
        #12;
        check_val("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check_val("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        if_req = 0; d_req = 0;
        @(negedge clk); rst_n = 1;

        // directed cases
        set_word(4, 32'h00C0FFEE);
        do_txn(1, 0, 3'd2, 16'h0010, 32'h0, got);
        check_val("fetch_word", got, 32'h00C0FFEE);
        set_word(4, 32'h11223344);
        do_txn(0, 1, 3'd0, 16'h0013, 32'h000000AB, got);
        check_val("sb_merge", mem[4], 32'hAB223344);
        do_txn(0, 0, 3'd0, 16'h0013, 32'h0, got);
        check_val("lb_sign", got, 32'hFFFFFFAB);
        do_txn(0, 0, 3'd4, 16'h0013, 32'h0, got);
        check_val("lbu_zero", got, 32'h000000AB);
        do_txn(0, 0, 3'd1, 16'h0012, 32'h0, got);
        check_val("lh_sign", got, 32'hFFFFAB22);
        do_txn(0, 0, 3'd5, 16'h0012, 32'h0, got);
        check_val("lhu_zero", got, 32'h0000AB22);
        do_txn(0, 1, 3'd2, 16'h0006, 32'hDEADBEEF, got);
        do_txn(1, 0, 3'd2, 16'h0012, 32'h0, got);

        // starvation: both requesters held high
        @(negedge clk);
        d_req = 1; d_we = 0; d_type = 3'd2; d_addr = 16'h0020; if_req = 1; if_addr = 16'h0020;
        k = 0;
        for (int c = 0; c < 100 && k < 10; c++) begin
            #1;
            check_val("arb_exclusive", {31'd0, d_ready & if_ready}, 32'd0);
            if (d_ready || if_ready) begin
                check_val("arb_grant_is_fetch", {31'd0, if_ready},
                          {31'd0, (k % (LIMIT + 1)) == LIMIT});
                $display("[TB] grant %0d -> %s", k, if_ready ? "I" : "D");
                k++;
            end
            @(negedge clk);
        end
        check_val("arb_grants", k, 10);
        d_req = 0; if_req = 0;
        repeat (4) @(negedge clk);

        // reset during the merge write of an SH
        sh_word = mem[4];
        d_req = 1; d_we = 1; d_type = 3'd1; d_addr = 16'h0012; d_wdata = 32'h00005A5A;
        #1;
        check_val("rst_sh_accept", {31'd0, d_ready}, 32'd1);
        @(posedge clk); #1; d_req = 0;
        @(posedge clk); #2;
        check_val("merge_we_high", {31'd0, mem_we}, 32'd1);
        #1; rst_n = 0; #1;
        check_val("async_we_drop", {31'd0, mem_we}, 32'd0);
        bad_rv = 0;
        repeat (3) begin @(negedge clk); if (d_rvalid || if_rvalid) bad_rv++; end
        rst_n = 1;
        repeat (2) begin @(negedge clk); if (d_rvalid || if_rvalid) bad_rv++; end
        check_val("rst_no_rvalid", bad_rv, 0);
        check_val("rst_word_kept", mem[4], sh_word);
        $display("[TB] txn reset during SH merge: word=%h", mem[4]);
        do_txn(0, 0, 3'd2, 16'h0010, 32'h0, got);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            fetch = ($urandom_range(0, 3) == 0);
            we    = $urandom_range(0, 1);
            typ   = types[$urandom_range(0, 6)];
            addr  = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                if (fetch || typ == 3'd2) addr[1:0] = 2'b00;
                else if (typ[1:0] == 2'd1) addr[0] = 1'b0;
            end
            do_txn(fetch, we, typ, addr, $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
